// File: rtl/cipher_stream.sv
// rtl/cipher_stream.sv - iterative AES-128/192/256 block encryption engine fed from an external round-key SRAM
//
// Purpose:
//   Encrypts one 128-bit block at a time. Each round fetches its round key from
//   the key SRAM, waits KEY_RD_LAT cycles, and applies one round. The engine
//   holds a single block in flight and has a one-entry output register.
//
// Ports:
//   clk, reset             clock (rising edge) and asynchronous active-low reset
//   in_valid/in_ready      plaintext handshake; in_data, in_mode, in_slot are sampled on accept
//   abort                  drops the block in flight (no effect while idle)
//   key_rd_en/key_addr     key SRAM read strobe and address (slot*15 + round)
//   key_rdata              round key, valid KEY_RD_LAT cycles after the strobe
//   out_valid/out_ready    ciphertext handshake; out_data and out_err are held until consumed
//   busy                   a block is in flight
module cipher_stream #(
  parameter int KEY_SLOTS  = 4,
  parameter int KEY_RD_LAT = 1,
  parameter int KEY_ADDR_W = $clog2(KEY_SLOTS * 15),
  localparam int SLOT_W    = (KEY_SLOTS > 1) ? $clog2(KEY_SLOTS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [127:0]          in_data,
  input  logic [1:0]            in_mode,
  input  logic [SLOT_W-1:0]     in_slot,
  input  logic                  abort,
  output logic                  key_rd_en,
  output logic [KEY_ADDR_W-1:0] key_addr,
  input  logic [127:0]          key_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [127:0]          out_data,
  output logic                  out_err,
  output logic                  busy
);

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [127:0]          r_data;
  logic [3:0]            r_round;
  logic [3:0]            r_nr;
  logic [SLOT_W-1:0]     r_slot;
  logic [2:0]            r_wait_cnt;
  logic [KEY_ADDR_W-1:0] r_key_addr;
  logic                  r_out_valid;
  logic                  r_out_err;
  logic [127:0]          r_out_data;

  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_legal;
  logic                  w_apply;
  logic                  w_last;
  logic [3:0]            w_in_nr;
  logic [KEY_ADDR_W-1:0] w_in_base;
  logic [KEY_ADDR_W-1:0] w_next_addr;
  logic [127:0]          w_sr;
  logic [127:0]          w_mc;
  logic [127:0]          w_round_out;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    // ~b == 255-b selects the byte counted from the top of the table.
    return SBOX_TAB[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes + ShiftRows; byte index = row + 4*column.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(r+4*c) +: 8] = sbox(s[8*(r+4*((c+r)%4)) +: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c+8 +: 8];
      a2 = s[32*c+16 +: 8];
      a3 = s[32*c+24 +: 8];
      o[32*c +: 8]    = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[32*c+8 +: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[32*c+16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[32*c+24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  always_comb begin
    w_in_nr = 4'd14;
    case (in_mode)
      2'b00:   w_in_nr = 4'd10;
      2'b01:   w_in_nr = 4'd12;
      default: w_in_nr = 4'd14;
    endcase
  end

  // in_ready is forced low while reset is asserted so every output reads 0.
  assign w_in_ready  = reset && (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && w_in_ready;
  assign w_legal     = (in_mode != 2'b11);
  assign w_last      = (r_round == r_nr);
  // The key is consumed on the last WAIT edge; abort wins over a pending apply.
  assign w_apply     = (r_state == S_WAIT) && (r_wait_cnt == 3'(KEY_RD_LAT - 1)) && !abort;
  assign w_in_base   = KEY_ADDR_W'(in_slot) * KEY_ADDR_W'(15);
  assign w_next_addr = KEY_ADDR_W'(r_slot) * KEY_ADDR_W'(15) + KEY_ADDR_W'(r_round) + KEY_ADDR_W'(1);

  assign w_sr = sub_shift(r_data);
  assign w_mc = mix_columns(w_sr);

  always_comb begin
    w_round_out = w_mc ^ key_rdata;
    if (r_round == 4'd0) begin
      w_round_out = r_data ^ key_rdata;
    end else if (w_last) begin
      w_round_out = w_sr ^ key_rdata;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_legal) w_state_nxt = S_FETCH;
      S_FETCH: w_state_nxt = S_WAIT;
      S_WAIT:  if (w_apply) w_state_nxt = w_last ? S_IDLE : S_FETCH;
      default: w_state_nxt = S_IDLE;
    endcase
    if (abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data      <= '0;
      r_round     <= '0;
      r_nr        <= '0;
      r_slot      <= '0;
      r_wait_cnt  <= '0;
      r_key_addr  <= '0;
      r_out_valid <= 1'b0;
      r_out_err   <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_accept) begin
        r_data  <= in_data;
        r_nr    <= w_in_nr;
        r_slot  <= in_slot;
        r_round <= 4'd0;
        if (w_legal) begin
          r_key_addr <= w_in_base;
        end
      end

      if (r_state == S_FETCH) begin
        r_wait_cnt <= 3'd0;
      end else if ((r_state == S_WAIT) && !w_apply) begin
        r_wait_cnt <= r_wait_cnt + 3'd1;
      end

      if (w_apply) begin
        r_data <= w_round_out;
        if (!w_last) begin
          r_round    <= r_round + 4'd1;
          r_key_addr <= w_next_addr;
        end
      end

      // Accept requires an empty or draining output register, so a load
      // never overwrites a result that has not been consumed.
      if (w_accept && !w_legal) begin
        r_out_valid <= 1'b1;
        r_out_err   <= 1'b1;
        r_out_data  <= '0;
      end else if (w_apply && w_last) begin
        r_out_valid <= 1'b1;
        r_out_err   <= 1'b0;
        r_out_data  <= w_round_out;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign key_rd_en = (r_state == S_FETCH);
  assign key_addr  = r_key_addr;
  assign out_valid = r_out_valid;
  assign out_err   = r_out_err;
  assign out_data  = r_out_data;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_cipher_stream.sv
// tb/tb_cipher_stream.sv - self-checking bench for cipher_stream at key read latency 1 and 3
module tb_cipher_stream;

  localparam logic [127:0] PT     = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] CT_128 = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
  localparam logic [127:0] CT_192 = 128'h91710deca070af6ee0df4c86a47ca9dd;
  localparam logic [127:0] CT_256 = 128'h8960494b9049fceabf456751cab7a28e;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_valid3 = 1'b0;
  logic [127:0] in_data = '0;
  logic [1:0]   in_mode = '0;
  logic [1:0]   in_slot = '0;
  logic         abort = 1'b0;
  logic         out_ready = 1'b1;

  logic         in_ready, key_rd_en, out_valid, out_err, busy;
  logic [5:0]   key_addr;
  logic [127:0] key_rdata, out_data;
  logic         in_ready3, key_rd_en3, out_valid3, out_err3, busy3;
  logic [5:0]   key_addr3;
  logic [127:0] key_rdata3, out_data3;
  logic [127:0] p1, p2;

  logic [127:0] mem [0:59];
  logic [7:0]   sb [0:255];
  logic [5:0]   addr_log [$];
  logic [5:0]   addr_log3 [$];
  int           time_log3 [$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  cipher_stream #(.KEY_SLOTS(4), .KEY_RD_LAT(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .in_slot(in_slot), .abort(abort),
    .key_rd_en(key_rd_en), .key_addr(key_addr), .key_rdata(key_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .busy(busy));

  cipher_stream #(.KEY_SLOTS(4), .KEY_RD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_data(in_data), .in_mode(in_mode), .in_slot(in_slot), .abort(abort),
    .key_rd_en(key_rd_en3), .key_addr(key_addr3), .key_rdata(key_rdata3),
    .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
    .out_err(out_err3), .busy(busy3));

  // Key SRAM models: data appears exactly LAT edges after the strobe, zero otherwise.
  always @(posedge clk) begin
    cyc        <= cyc + 1;
    key_rdata  <= key_rd_en ? mem[key_addr] : 128'h0;
    p1         <= key_rd_en3 ? mem[key_addr3] : 128'h0;
    p2         <= p1;
    key_rdata3 <= p2;
    if (key_rd_en) addr_log.push_back(key_addr);
    if (key_rd_en3) begin
      addr_log3.push_back(key_addr3);
      time_log3.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse in GF(2^8), then the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, 8'(x));
      end
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                  ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic load_key(input int slot, input int nk, input logic [255:0] key);
    logic [7:0] w [0:239];
    logic [7:0] t [0:3];
    logic [7:0] tmp;
    logic [7:0] rc;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int j = 0; j < 4 * nk; j++) w[j] = key[8*j +: 8];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      for (int j = 0; j < 4; j++) t[j] = w[4*(i-1)+j];
      if (i % nk == 0) begin
        tmp = t[0]; t[0] = t[1]; t[1] = t[2]; t[2] = t[3]; t[3] = tmp;
        for (int j = 0; j < 4; j++) t[j] = sb[t[j]];
        t[0] = t[0] ^ rc;
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        for (int j = 0; j < 4; j++) t[j] = sb[t[j]];
      end
      for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-nk)+j] ^ t[j];
    end
    for (int k = 0; k <= nr; k++)
      for (int j = 0; j < 16; j++) mem[slot*15+k][8*j +: 8] = w[16*k+j];
  endtask

  function automatic logic [127:0] ref_enc(input logic [127:0] pt, input int slot, input int nr);
    logic [7:0] s [0:15];
    logic [7:0] u [0:15];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] res;
    for (int j = 0; j < 16; j++) s[j] = pt[8*j +: 8] ^ mem[slot*15][8*j +: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int j = 0; j < 16; j++) u[j] = sb[s[j]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r+4*c] = u[r+4*((c+r)%4)];
      if (rnd < nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int j = 0; j < 16; j++) s[j] = s[j] ^ mem[slot*15+rnd][8*j +: 8];
    end
    for (int j = 0; j < 16; j++) res[8*j +: 8] = s[j];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Offers one block, scrambles the inputs after accept, waits for out_valid.
  // lat = edges from accept to the edge that raised out_valid; -1 on timeout.
  task automatic run_block(input int which, input logic [127:0] d, input logic [1:0] m,
                           input logic [1:0] sl, output logic [127:0] res,
                           output logic err, output int lat);
    int n;
    int acc;
    in_data = d; in_mode = m; in_slot = sl;
    n = 0;
    while (((which == 0) ? in_ready : in_ready3) !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (which == 0) in_valid = 1'b1; else in_valid3 = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    in_valid = 1'b0; in_valid3 = 1'b0;
    in_data = rand128(); in_mode = 2'($urandom_range(0, 2)); in_slot = 2'($urandom_range(0, 3));
    n = 0;
    while (((which == 0) ? out_valid : out_valid3) !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    res = (which == 0) ? out_data : out_data3;
    err = (which == 0) ? out_err : out_err3;
    lat = (n >= 200) ? -1 : cyc - acc;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, key_rd_en, key_addr, out_valid, out_err, busy, out_data} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%b rd=%b addr=%0d ov=%b err=%b busy=%b data=%h exp all 0",
               in_ready, key_rd_en, key_addr, out_valid, out_err, busy, out_data);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || in_ready3 !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset got %b/%b exp 1/1", in_ready, in_ready3);
    end
  endtask

  task automatic check_seq(input string name, input int which, input int n0,
                           input int base, input int cnt);
    int ok;
    int got;
    ok = 1;
    got = (which == 0) ? addr_log.size() - n0 : addr_log3.size() - n0;
    if (got != cnt) ok = 0;
    else
      for (int k = 0; k < cnt; k++)
        if (((which == 0) ? addr_log[n0+k] : addr_log3[n0+k]) !== 6'(base + k)) ok = 0;
    checks++;
    if (ok == 0) begin
      failures++;
      $display("FAIL %s got %0d reads exp %0d reads at %0d..%0d", name, got, cnt, base, base + cnt - 1);
    end
  endtask

  task automatic test_fips(input int which, input logic [1:0] m, input logic [127:0] exp_ct,
                           input int exp_lat, input int base, input int cnt);
    logic [127:0] res;
    logic err;
    int lat;
    int n0;
    n0 = (which == 0) ? addr_log.size() : addr_log3.size();
    run_block(which, PT, m, m, res, err, lat);
    checks++;
    if ({err, res} !== {1'b0, exp_ct}) begin
      failures++;
      $display("FAIL fips_mode%0d_lat%0d got err=%b %h exp err=0 %h", m, which, err, res, exp_ct);
    end
    checks++;
    if (lat !== exp_lat) begin
      failures++;
      $display("FAIL latency_mode%0d_dut%0d got %0d exp %0d", m, which, lat, exp_lat);
    end
    check_seq($sformatf("key_addr_mode%0d_dut%0d", m, which), which, n0, base, cnt);
  endtask

  task automatic test_lat3_spacing();
    int n0;
    int ok;
    logic [127:0] res;
    logic err;
    int lat;
    n0 = time_log3.size();
    run_block(1, PT, 2'd2, 2'd2, res, err, lat);
    ok = (time_log3.size() - n0 == 15) ? 1 : 0;
    for (int k = 1; k < 15 && ok == 1; k++)
      if (time_log3[n0+k] - time_log3[n0+k-1] != 4) ok = 0;
    checks++;
    if (ok == 0 || res !== CT_256) begin
      failures++;
      $display("FAIL lat3_strobe_spacing got %0d strobes data %h exp 15 strobes 4 apart data %h",
               time_log3.size() - n0, res, CT_256);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] d1, d2, held, res;
    logic err;
    int lat;
    int acc;
    int n;
    d1 = rand128();
    d2 = rand128();
    out_ready = 1'b0;
    run_block(0, d1, 2'd0, 2'd0, held, err, lat);
    checks++;
    if (held !== ref_enc(d1, 0, 10)) begin
      failures++;
      $display("FAIL stall_result got %h exp %h", held, ref_enc(d1, 0, 10));
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, out_data} !== {1'b1, 1'b0, held}) begin
        failures++;
        $display("FAIL stall_hold cycle %0d got ov=%b rdy=%b %h exp ov=1 rdy=0 %h",
                 i, out_valid, in_ready, out_data, held);
      end
    end
    in_data = d2; in_mode = 2'd2; in_slot = 2'd2;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL drain_ready got %b exp 1", in_ready);
    end
    @(posedge clk); #1;
    acc = cyc;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, busy} !== 2'b01) begin
      failures++;
      $display("FAIL drain_and_accept got ov=%b busy=%b exp ov=0 busy=1", out_valid, busy);
    end
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    res = out_data;
    lat = cyc - acc;
    checks++;
    if (res !== ref_enc(d2, 2, 14) || lat != 30) begin
      failures++;
      $display("FAIL after_drain got %h lat %0d exp %h lat 30", res, lat, ref_enc(d2, 2, 14));
    end
  endtask

  task automatic test_abort();
    logic [127:0] res;
    logic [127:0] d;
    logic err;
    int lat;
    int seen;
    in_data = rand128(); in_mode = 2'd0; in_slot = 2'd0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if ({key_rd_en, key_addr} !== {1'b1, 6'd5}) begin
      failures++;
      $display("FAIL round5_fetch got rd=%b addr=%0d exp rd=1 addr=5", key_rd_en, key_addr);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle got busy=%b exp 0", busy);
    end
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL aborted_output got %0d valid cycles exp 0", seen);
    end
    d = rand128();
    run_block(0, d, 2'd0, 2'd3, res, err, lat);
    checks++;
    if ({err, res} !== {1'b0, ref_enc(d, 3, 10)} || lat != 22) begin
      failures++;
      $display("FAIL post_abort got err=%b %h lat %0d exp err=0 %h lat 22", err, res, lat, ref_enc(d, 3, 10));
    end
  endtask

  task automatic test_illegal();
    int n0;
    n0 = addr_log.size();
    in_data = rand128(); in_mode = 2'b11; in_slot = 2'd1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_err, busy, out_data} !== {1'b1, 1'b1, 1'b0, 128'h0}) begin
      failures++;
      $display("FAIL illegal_result got ov=%b err=%b busy=%b %h exp ov=1 err=1 busy=0 0",
               out_valid, out_err, busy, out_data);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || addr_log.size() != n0) begin
      failures++;
      $display("FAIL illegal_no_reads got ov=%b reads=%0d exp ov=0 reads=0", out_valid, addr_log.size() - n0);
    end
  endtask

  task automatic test_random();
    logic [127:0] d, res;
    logic [1:0] m, sl;
    logic err;
    int lat;
    int nr;
    for (int i = 0; i < 6; i++) begin
      m = 2'($urandom_range(0, 2));
      sl = (m == 2'd0 && $urandom_range(0, 1) == 1) ? 2'd3 : m;
      nr = 10 + 2 * int'(m);
      d = rand128();
      run_block(0, d, m, sl, res, err, lat);
      checks++;
      if ({err, res} !== {1'b0, ref_enc(d, int'(sl), nr)}) begin
        failures++;
        $display("FAIL random_%0d mode %0d got err=%b %h exp err=0 %h", i, m, err, res, ref_enc(d, int'(sl), nr));
      end
      checks++;
      if (lat != (nr + 1) * 2) begin
        failures++;
        $display("FAIL random_latency_%0d got %0d exp %0d", i, lat, (nr + 1) * 2);
      end
    end
  endtask

  task automatic test_reset_midround();
    logic [127:0] d, res;
    logic err;
    int lat;
    in_data = rand128(); in_mode = 2'd1; in_slot = 2'd1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if ({in_ready, key_rd_en, key_addr, out_valid, out_err, busy, out_data, out_data3, busy3} !== '0) begin
      failures++;
      $display("FAIL reset_midround got rdy=%b rd=%b addr=%0d ov=%b err=%b busy=%b %h dut3 %h exp all 0",
               in_ready, key_rd_en, key_addr, out_valid, out_err, busy, out_data, out_data3);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    d = rand128();
    run_block(0, d, 2'd0, 2'd0, res, err, lat);
    checks++;
    if ({err, res} !== {1'b0, ref_enc(d, 0, 10)} || lat != 22) begin
      failures++;
      $display("FAIL post_reset got err=%b %h lat %0d exp err=0 %h lat 22", err, res, lat, ref_enc(d, 0, 10));
    end
  endtask

  initial begin
    logic [255:0] fkey;
    build_sbox();
    for (int j = 0; j < 32; j++) fkey[8*j +: 8] = 8'(j);
    load_key(0, 4, fkey);
    load_key(1, 6, fkey);
    load_key(2, 8, fkey);
    load_key(3, 4, {128'h0, rand128()});

    test_reset();
    test_fips(0, 2'd0, CT_128, 22, 0, 11);
    test_fips(0, 2'd1, CT_192, 26, 15, 13);
    test_fips(0, 2'd2, CT_256, 30, 30, 15);
    test_fips(1, 2'd2, CT_256, 60, 30, 15);
    test_lat3_spacing();
    test_backpressure();
    test_abort();
    test_illegal();
    test_random();
    test_reset_midround();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
